wb_stage_lsu: RTL
=================

// Module: wb_stage_lsu
// PURPOSE
//  Parametrised memory/writeback stage for the RISC-V core.
//  - Sits after execute; stage register carries instruction, ALU result, PC+4 and immediate.
//  - Issues loads to a variable-latency data memory and aligns/sign-extends the returned data.
//  - Selects writeback data and drives the register-file write port.
//  - Adds valid/ready flow control, flush, misaligned-load detection and memory timeout.
// PARAMETERS
//  XLEN       32   datapath width (only 32 supported; checked at elaboration)
//  REG_AW     5    register-file address width
//  TIMEOUT_W  8    width of memory-wait counter; timeout after 2**TIMEOUT_W-1 idle cycles
// PORTS
//  clk             in   1       core clock
//  reset_n         in   1       asynchronous active-low reset
//  in_valid        in   1       execute stage presents an instruction
//  in_ready        out  1       stage can accept; transfer when in_valid&&in_ready at posedge
//  flush           in   1       synchronous kill of the held instruction
//  instruction_in  in   XLEN    instruction word
//  alu_out         in   XLEN    ALU result / load effective address
//  pc_plus_4       in   XLEN    PC+4 for JAL/JALR link
//  immediate       in   XLEN    decoded immediate for LUI
//  mem_req         out  1       one-cycle load request
//  mem_addr        out  XLEN    word address {alu_out_reg[XLEN-1:2],2'b00}
//  mem_rvalid      in   1       memory returns mem_rdata this cycle
//  mem_rdata       in   XLEN    word read data
//  wb_en           out  1       register-file write enable
//  wb_addr         out  REG_AW  destination register = instr_reg[11:7]
//  wb_data         out  XLEN    writeback data
//  misaligned_err  out  1       one-cycle pulse: misaligned load dropped
//  timeout_err     out  1       one-cycle pulse: load abandoned after timeout
// BEHAVIOUR
//  Reset: state=IDLE, stage regs=0; mem_req, wb_en, both err pulses, in_ready=0 during reset.
//  in_ready=1 from the first cycle after reset deassertion.
//  States and transitions:
//  - IDLE (empty)
//  - HOLD (non-load held)
//  - WAIT (load outstanding)
//  - DRAIN (flushed load outstanding)
//  Capture into HOLD or WAIT on in_valid&&in_ready; else IDLE.
//  HOLD:
//  - wb_en asserted for the single cycle in HOLD; always 1-cycle latency.
//  - in_ready=1; next capture (or IDLE) at the next edge.
//  WAIT:
//  - mem_req=1 only in the first WAIT cycle.
//  - Stay until mem_rvalid.
//  - In the mem_rvalid cycle: wb_en=1 with aligned data; in_ready=1 (back-to-back allowed).
//  - Counter increments each WAIT cycle without rvalid.
//  - Counter at max: timeout_err pulse, no write, go IDLE.
//  - Otherwise in_ready=0.
//  DRAIN:
//  - in_ready=0, no writeback.
//  - Leave to IDLE on mem_rvalid (data discarded) or timeout (no error pulse).
//  Misaligned load (LH/LHU with addr[0]=1, LW with addr[1:0]!=0):
//  - No mem_req; misaligned_err and no write in the cycle after capture.
//  - Treated like HOLD.
//  Writeback select by opcode [6:0]:
//  - 0000011 LOAD -> aligned mem_rdata.
//  - 1101111/1100111 JAL/JALR -> pc_plus_4.
//  - 0110111 LUI -> immediate.
//  - 0010011/0110011/0010111 -> alu_out.
//  - All other opcodes -> wb_en=0.
//  Load alignment by funct3 (byte offset addr[1:0]):
//  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//  wb_en forced 0 when wb_addr==0.
//  flush:
//  - In HOLD: kills the write, goes IDLE.
//  - In WAIT: kills the write, goes DRAIN, even if mem_rvalid arrives that cycle.
//  - flush with in_valid: the new instruction is NOT captured.
//  - flush wins over all simultaneous events.
//  reset_n low mid-operation clears state at once; a late mem_rvalid after reset is ignored in IDLE.
// TESTING
//  - ADDI x5, alu_out=0x10, in_valid 1 cycle -> next cycle wb_en=1, wb_addr=5, wb_data=0x10.
//  - LB x6, addr 0x103, mem_rdata=0x80FFFFFF, rvalid 3 cycles after mem_req -> wb_data=0xFFFFFF80; in_ready low 3 cycles.
//  - LHU x7, addr 0x102, mem_rdata=0xBEEF1234 -> wb_data=0x0000BEEF.
//  - LW addr 0x101 -> misaligned_err pulse, mem_req=0, wb_en=0.
//  - LW in WAIT, flush, rvalid 2 cycles later -> wb_en never 1; in_ready returns 1 the cycle after rvalid.
//  - LW with no rvalid ever -> timeout_err after 255 cycles, state IDLE.
//  - JAL x1 with pc_plus_4=0x84 -> wb_data=0x84.
//  - ADDI x0 -> wb_en=0.

Source files
------------

// File: rtl/wb_stage_lsu.sv
// wb_stage_lsu: memory/writeback stage of the RISC-V core.
//   Holds one instruction from execute. The stage either writes it back one
//   cycle after capture, or issues a load to a variable-latency data memory.
//   For a load it waits for the returned word, then aligns and extends it
//   before writing it back. Also handles flush, misaligned-load drop and
//   memory timeout.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid / in_ready    handshake with execute; instruction_in, alu_out,
//                          pc_plus_4, immediate are captured on transfer
//   flush                  kill the held instruction, block capture this cycle
//   mem_req / mem_addr     one-cycle word-aligned load request
//   mem_rvalid / mem_rdata load response
//   wb_en/wb_addr/wb_data  register-file write port
//   misaligned_err         pulse: misaligned load dropped
//   timeout_err            pulse: load abandoned after timeout
module wb_stage_lsu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [XLEN-1:0]   instruction_in,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   pc_plus_4,
    input  logic [XLEN-1:0]   immediate,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              misaligned_err,
    output logic              timeout_err
);

    if (XLEN != 32) begin : g_xlen_check
        $error("wb_stage_lsu: only XLEN=32 is supported");
    end

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StHold  = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    logic [1:0]           state_q, state_d;
    logic [14:0]          instr_q;     // only opcode, rd and funct3 are used
    logic [XLEN-1:0]      alu_q, pc4_q, imm_q;
    logic                 misal_q;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic unused_instr_hi;
    assign unused_instr_hi = ^instruction_in[XLEN-1:15];

    // Misalignment is decided at capture so the held instruction never issues.
    logic [6:0] in_op;
    logic [2:0] in_f3;
    logic       in_misal, in_is_load, capture;

    assign in_op      = instruction_in[6:0];
    assign in_f3      = instruction_in[14:12];
    assign in_is_load = (in_op == OpLoad);
    assign in_misal   = in_is_load &&
                        (((in_f3[1:0] == 2'b01) && alu_out[0]) ||
                         ((in_f3 == 3'b010) && (alu_out[1:0] != 2'b00)));
    assign capture    = in_valid && in_ready;

    // Held instruction decode
    logic [6:0] op;
    logic [2:0] funct3;
    logic       rd_nz, has_wb, cnt_max;

    assign op      = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign rd_nz   = |instr_q[11:7];
    assign cnt_max = &cnt_q;
    assign has_wb  = (op == OpLoad) || (op == OpJal) || (op == OpJalr) || (op == OpLui) ||
                     (op == OpImm) || (op == OpReg) || (op == OpAuipc);

    assign wb_addr  = REG_AW'(instr_q[11:7]);
    assign mem_addr = {alu_q[XLEN-1:2], 2'b00};

    // Load alignment: byte lane selected by addr[1:0], half lane by addr[1]
    logic [XLEN-1:0] rdata_shift, load_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin
        rdata_shift = mem_rdata >> {alu_q[1:0], 3'b000};
        ld_byte     = rdata_shift[7:0];
        ld_half     = alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (op)
            OpLoad:        wb_data = load_data;
            OpJal, OpJalr: wb_data = pc4_q;
            OpLui:         wb_data = imm_q;
            default:       wb_data = alu_q;
        endcase
    end

    // Next state, handshake and pulses
    logic ready_raw;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ready_raw      = 1'b0;
        mem_req        = 1'b0;
        wb_en          = 1'b0;
        misaligned_err = 1'b0;
        timeout_err    = 1'b0;

        case (state_q)
            StIdle: begin
                ready_raw = 1'b1;
            end
            StHold: begin
                ready_raw      = 1'b1;
                state_d        = StIdle;
                wb_en          = !flush && has_wb && rd_nz && !misal_q;
                misaligned_err = !flush && misal_q;
            end
            StWait: begin
                // Counter is zero only in the first WAIT cycle
                mem_req = (cnt_q == '0);
                if (flush) begin
                    // Response still owed by memory; drain it before going idle
                    state_d = StDrain;
                    cnt_d   = cnt_max ? cnt_q : cnt_q + TIMEOUT_W'(1);
                end else if (mem_rvalid) begin
                    ready_raw = 1'b1;
                    wb_en     = rd_nz;
                    state_d   = StIdle;
                end else if (cnt_max) begin
                    timeout_err = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: begin // StDrain
                if (mem_rvalid || cnt_max) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
        endcase

        in_ready = ready_raw && !flush && reset_n;

        if (capture) begin
            state_d = (in_is_load && !in_misal) ? StWait : StHold;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            alu_q   <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            misal_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                instr_q <= instruction_in[14:0];
                alu_q   <= alu_out;
                pc4_q   <= pc_plus_4;
                imm_q   <= immediate;
                misal_q <= in_misal;
            end
        end
    end

endmodule
